// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch pointer, issues in-order word fetches,
// pairs responses with their PC and buffers them for decode behind valid/ready.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 2;

  logic [XLEN-1:0] pend_mem      [DEPTH];
  logic [XLEN-1:0] fifo_pc_mem   [DEPTH];
  logic [31:0]     fifo_data_mem [DEPTH];

  logic [AW-1:0] pend_wr, pend_rd, fifo_wr, fifo_rd;
  logic [CW-1:0] fifo_count, outstanding, drop_count, drop_sum;
  logic [OW-1:0] occ;
  logic          req_fire, rsp_drop, rsp_take, inst_pop;

  // Every buffered, in-flight or to-be-dropped word holds one slot of the budget,
  // so a FIFO push can never find the FIFO full.
  assign occ            = OW'(fifo_count) + OW'(outstanding) + OW'(drop_count);
  assign imem_req_valid = resetn && !redirect_valid && (occ < OW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_count != '0);
  assign rsp_take = imem_rsp_valid && !redirect_valid && (drop_count == '0) && (outstanding != '0);

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = fifo_data_mem[fifo_rd];
  assign inst_pc    = fifo_pc_mem[fifo_rd];
  assign inst_pop   = inst_valid && inst_ready && !redirect_valid;

  assign drop_sum = drop_count + outstanding;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      pend_wr     <= '0;
      pend_rd     <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      pend_wr     <= '0;
      pend_rd     <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      // A response landing in the redirect cycle retires one of the words now owed.
      drop_count  <= drop_sum - CW'(imem_rsp_valid && (drop_sum != '0));
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pend_wr  <= pend_wr + AW'(1);
      end
      if (rsp_take) begin
        pend_rd <= pend_rd + AW'(1);
        fifo_wr <= fifo_wr + AW'(1);
      end
      if (inst_pop) fifo_rd <= fifo_rd + AW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      fifo_count  <= fifo_count + CW'(rsp_take) - CW'(inst_pop);
      if (rsp_drop) drop_count <= drop_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pend_mem[pend_wr] <= fetch_pc;
    if (rsp_take) begin
      fifo_pc_mem[fifo_wr]   <= pend_mem[pend_rd];
      fifo_data_mem[fifo_wr] <= imem_rsp_data;
    end
  end

endmodule
